// File: rtl/trigger_ctrl_pkg.sv
// Shared definitions for the stopwatch trigger controller: FSM state
// encodings and operating-mode selectors.
package trigger_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_LAP  = 2'b10,
    ST_STOP = 2'b11
  } state_t;

  localparam int MODE_LEGACY = 0;
  localparam int MODE_FSM    = 1;

  // Trigger bit positions inside the three-wide pulse vector.
  localparam int TRIG_START_STOP = 0;
  localparam int TRIG_LAP        = 1;
  localparam int TRIG_CLEAR      = 2;

  // The counter runs while timing, whether or not the display is frozen.
  function automatic logic state_counts(input state_t st);
    return (st == ST_RUN) || (st == ST_LAP);
  endfunction

endpackage

// File: rtl/trigger_ctrl_conditioner.sv
// Per-button conditioning: multi-flop synchroniser, stable-time debounce
// and a single-cycle pulse on each debounced rising edge.
module trig_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_CYCLES  = 50000
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic raw_in,
  output logic level_o,
  output logic pulse_o
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_W-1:0]       cnt;
  logic                   sync_val;

  assign sync_val = sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Any cycle that agrees with the current level restarts the stability count.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      level_o <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      pulse_o <= 1'b0;
      if (sync_val == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        level_o <= sync_val;
        pulse_o <= sync_val;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/trigger_ctrl.sv
// Stopwatch trigger controller: conditions three buttons and drives the
// counter/display controls from a 4-state FSM or the legacy toggle.
module trigger_ctrl
  import trigger_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_CYCLES  = 50000,
  parameter int MODE        = 1
) (
  input  logic       sys_clk,
  input  logic       reset_n,
  input  logic       trig_start_stop,
  input  logic       trig_lap,
  input  logic       trig_clear,
  output logic       count_enb,
  output logic       latch_count,
  output logic       count_init,
  output logic [1:0] state_o,
  output logic [2:0] trig_pulse
);

  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] pulse;

  assign raw = {trig_clear, trig_lap, trig_start_stop};

  for (genvar i = 0; i < 3; i++) begin : g_cond
    trig_conditioner #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_W       (DEB_W),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_cond (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .raw_in  (raw[i]),
      .level_o (level[i]),
      .pulse_o (pulse[i])
    );
  end

  assign trig_pulse = pulse;

  state_t     state, state_next;
  logic       k, k_next;
  logic       enb_next, latch_next, init_next;
  logic [1:0] state_o_next;
  logic       evt_clear, evt_ss, evt_lap;

  // Single event per cycle; a higher-priority pulse swallows the others.
  assign evt_clear = pulse[TRIG_CLEAR];
  assign evt_ss    = pulse[TRIG_START_STOP] & ~pulse[TRIG_CLEAR];
  assign evt_lap   = pulse[TRIG_LAP] & ~pulse[TRIG_START_STOP] & ~pulse[TRIG_CLEAR];

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      k           <= 1'b0;
      count_enb   <= 1'b0;
      latch_count <= 1'b0;
      count_init  <= 1'b0;
      state_o     <= 2'b00;
    end else begin
      state       <= state_next;
      k           <= k_next;
      count_enb   <= enb_next;
      latch_count <= latch_next;
      count_init  <= init_next;
      state_o     <= state_o_next;
    end
  end

  always_comb begin
    state_next   = state;
    k_next       = k;
    init_next    = 1'b0;
    enb_next     = 1'b0;
    latch_next   = 1'b0;
    state_o_next = 2'b00;

    if (MODE == MODE_LEGACY) begin
      if (pulse[TRIG_START_STOP]) begin
        k_next = ~k;
      end
      enb_next     = k_next;
      latch_next   = k_next;
      init_next    = k_next;
      state_o_next = {1'b0, k_next};
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (evt_clear) begin
            init_next = 1'b1;
          end else if (evt_ss) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (evt_ss) begin
            state_next = ST_STOP;
          end else if (evt_lap) begin
            state_next = ST_LAP;
          end
        end
        ST_LAP: begin
          if (evt_ss) begin
            state_next = ST_STOP;
          end else if (evt_lap) begin
            state_next = ST_RUN;
          end
        end
        ST_STOP: begin
          if (evt_clear) begin
            state_next = ST_IDLE;
            init_next  = 1'b1;
          end else if (evt_ss) begin
            state_next = ST_RUN;
          end
        end
        default: state_next = ST_IDLE;
      endcase
      enb_next     = state_counts(state_next);
      latch_next   = (state_next == ST_LAP);
      state_o_next = state_next;
    end
  end

endmodule
